// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access at a time.
// Formats byte/half/word stores and extracts/extends load data.
module load_store_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic        store_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [3:0]  cnt_q;

  logic        mis_d;
  logic [3:0]  lmask_d;
  logic [3:0]  pmask_d;
  logic [31:0] ldata_d;
  logic [31:0] pdata_d;
  logic [31:0] lrd_d;
  logic [7:0]  rb_d;
  logic [15:0] rh_d;
  logic [31:0] ext_d;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign req_ready = (state_q == S_IDLE);

  // Alignment check and physical store lanes/data from the live request.
  always_comb begin
    mis_d = ((req_size == 2'd1) && req_addr[0]) ||
            ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    lmask_d = 4'b1111;
    ldata_d = req_wdata;
    case (req_size)
      2'd0: begin
        lmask_d = 4'b0001 << req_addr[1:0];
        ldata_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lmask_d = 4'b0011 << {req_addr[1], 1'b0};
        ldata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    pmask_d = BYTE_SWAP ?
      {lmask_d[0], lmask_d[1], lmask_d[2], lmask_d[3]} : lmask_d;
    pdata_d = BYTE_SWAP ? bswap(ldata_d) : ldata_d;
  end

  // Logical view of read data, lane select and sign/zero extension.
  always_comb begin
    lrd_d = BYTE_SWAP ? bswap(mem_dout) : mem_dout;
    rb_d  = lrd_d[{off_q, 3'b000} +: 8];
    rh_d  = off_q[1] ? lrd_d[31:16] : lrd_d[15:0];
    case (size_q)
      2'd0:    ext_d = uns_q ? {24'b0, rb_d} : {{24{rb_d[7]}}, rb_d};
      2'd1:    ext_d = uns_q ? {16'b0, rh_d} : {{16{rh_d[15]}}, rh_d};
      default: ext_d = lrd_d;
    endcase
  end

  // Request FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      store_q    <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      cnt_q      <= 4'd0;
      mem_en     <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 2'd0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 4'b0000;
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          store_q    <= req_store;
          uns_q      <= req_unsigned;
          size_q     <= req_size;
          off_q      <= req_addr[1:0];
          resp_rdata <= '0;
          if (req_size == 2'd3) begin
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 2'd2;
          end else if (mis_d) begin
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 2'd1;
          end else begin
            state_q  <= S_ACCESS;
            mem_en   <= 1'b1;
            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_we   <= req_store ? pmask_d : 4'b0000;
            mem_din  <= pdata_d;
          end
        end
        S_ACCESS: begin
          state_q <= S_WAIT;
          cnt_q   <= 4'(MEM_LAT);
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 2'd0;
            resp_rdata <= store_q ? 32'd0 : ext_d;
          end
        end
        S_RESP: if (resp_ready) begin
          state_q    <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (lat 1/swap, lat 4/no swap)
// against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rstn;
  logic clr_mem;
  always #5 clk = ~clk;

  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_store    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic [1:0]  resp_err     [2];
  logic        mem_en       [2];
  logic [31:0] mem_addr     [2];
  logic [3:0]  mem_we       [2];
  logic [31:0] mem_din      [2];
  logic [31:0] mem_dout     [2];

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_mem [2][256];

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [7:0]  en_cyc;
    logic [7:0]  en_cnt;
    logic [7:0]  rv_cyc;
    logic [7:0]  stray;
    logic [7:0]  unstable;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] addr;
    logic        rdy;
  } obs_t;

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic bit swp_of(input int u);
    return (u == 0);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : unit
    localparam int L = (g == 0) ? 1 : 4;
    localparam bit S = (g == 0);
    logic [7:0]  pmem [256];
    logic [31:0] pd [16];
    logic        pv [16];
    logic [31:0] rd;

    load_store_unit #(
      .ADDR_W(32), .MEM_LAT(L), .BYTE_SWAP(S)
    ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_store(req_store[g]), .req_size(req_size[g]),
      .req_unsigned(req_unsigned[g]), .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]),
      .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_we(mem_we[g]),
      .mem_din(mem_din[g]), .mem_dout(mem_dout[g])
    );

    always_comb begin
      rd = '0;
      for (int p = 0; p < 4; p++)
        rd[8*p +: 8] = pmem[{mem_addr[g][7:2], 2'(S ? 3 - p : p)}];
    end

    always @(posedge clk) begin
      if (clr_mem) begin
        for (int i = 0; i < 256; i++) pmem[i] <= 8'h00;
      end else if (mem_en[g]) begin
        for (int p = 0; p < 4; p++)
          if (mem_we[g][p])
            pmem[{mem_addr[g][7:2], 2'(S ? 3 - p : p)}] <= mem_din[g][8*p +: 8];
      end
      pv[0] <= mem_en[g] && (mem_we[g] == 4'b0000);
      pd[0] <= rd;
      for (int i = 1; i < 16; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end

    assign mem_dout[g] = pv[L-1] ? pd[L-1] : 32'hDEAD_BEEF;
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] exp_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 2'd2;
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_load(input int u, input logic [1:0] sz,
                                           input bit un, input logic [31:0] a);
    int b = int'(a[7:0]);
    logic [31:0] v = 0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = ref_mem[u][b + i];
    if (sz == 2'd0 && !un) v = {{24{v[7]}}, v[7:0]};
    if (sz == 2'd1 && !un) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic void model_store(input int u, input logic [1:0] sz,
                                      input logic [31:0] a, input logic [31:0] w);
    int b = int'(a[7:0]);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[u][b + i] = w[8*i +: 8];
  endfunction

  function automatic void exp_store(input int u, input logic [1:0] sz,
                                    input logic [31:0] a, input logic [31:0] w,
                                    output logic [3:0] we, output logic [31:0] din);
    int n = nbytes(sz);
    int off = int'(a[1:0]);
    we = 0;
    din = 0;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = swp_of(u) ? 3 - k : k;
      if (k / n == off / n) we[p] = 1'b1;
      din[8*p +: 8] = w[8*(k % n) +: 8];
    end
  endfunction

  task automatic do_op(input int u, input bit st, input logic [1:0] sz,
                       input bit un, input logic [31:0] a, input logic [31:0] w,
                       input int hold, output obs_t o);
    int cyc;
    bit done;
    o = '0;
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_store[u] = st;
    req_size[u] = sz;
    req_unsigned[u] = un;
    req_addr[u] = a;
    req_wdata[u] = w;
    resp_ready[u] = (hold == 0);
    o.rdy = req_ready[u];
    @(negedge clk);
    req_valid[u] = 1'b0;
    req_store[u] = 1'($urandom);
    req_size[u] = 2'($urandom);
    req_unsigned[u] = 1'($urandom);
    req_addr[u] = $urandom;
    req_wdata[u] = $urandom;
    cyc = 1;
    done = 0;
    while (!done && cyc < 40) begin
      if (mem_en[u]) begin
        o.en_cnt = o.en_cnt + 1;
        o.en_cyc = 8'(cyc);
        o.we = mem_we[u];
        o.din = mem_din[u];
        o.addr = mem_addr[u];
      end else if (mem_we[u] != 4'b0000) begin
        o.stray = o.stray + 1;
      end
      if (resp_valid[u]) begin
        done = 1;
        o.rv_cyc = 8'(cyc);
        o.rdata = resp_rdata[u];
        o.err = resp_err[u];
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL resp_timeout u=%0d got no resp_valid want within 40 cycles", u);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (resp_valid[u] !== 1'b1 || resp_rdata[u] !== o.rdata ||
            resp_err[u] !== o.err || req_ready[u] !== 1'b0 || mem_en[u] !== 1'b0)
          o.unstable = o.unstable + 1;
      end
      resp_ready[u] = 1'b1;
      @(negedge clk);
      if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1)
        o.unstable = o.unstable + 1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clr_mem = 1'b1;
    repeat (3) @(negedge clk);
    clr_mem = 1'b0;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 256; i++) ref_mem[u][i] = 8'h00;
      checks++;
      if (req_ready[u] !== 1'b1 || resp_valid[u] !== 1'b0 ||
          mem_en[u] !== 1'b0 || mem_we[u] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ctrl u=%0d got rdy=%b rv=%b en=%b we=%b want 1 0 0 0",
                 u, req_ready[u], resp_valid[u], mem_en[u], mem_we[u]);
      end
      checks++;
      if (resp_rdata[u] !== 0 || resp_err[u] !== 0 ||
          mem_din[u] !== 0 || mem_addr[u] !== 0) begin
        failures++;
        $display("FAIL reset_data u=%0d got rd=%h err=%h din=%h addr=%h want all 0",
                 u, resp_rdata[u], resp_err[u], mem_din[u], mem_addr[u]);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_store_word();
    obs_t o;
    do_op(0, 1, 2'd2, 0, 32'h10, 32'h11223344, 0, o);
    model_store(0, 2'd2, 32'h10, 32'h11223344);
    checks++;
    if (o.en_cnt != 1 || o.en_cyc != 1) begin
      failures++;
      $display("FAIL sw_strobe got cnt=%0d cyc=%0d want 1 1", o.en_cnt, o.en_cyc);
    end
    checks++;
    if (o.addr !== 32'h10 || o.we !== 4'b1111) begin
      failures++;
      $display("FAIL sw_addr_we got %h %b want 00000010 1111", o.addr, o.we);
    end
    checks++;
    if (o.din !== 32'h44332211) begin
      failures++;
      $display("FAIL sw_din got %h want 44332211", o.din);
    end
    checks++;
    if (o.rv_cyc != 3 || o.err !== 2'd0 || o.rdata !== 32'd0) begin
      failures++;
      $display("FAIL sw_resp got cyc=%0d err=%0d rd=%h want 3 0 0", o.rv_cyc, o.err, o.rdata);
    end
  endtask

  task automatic test_load_ext();
    obs_t o;
    logic [1:0]  sz [5];
    bit          un [5];
    logic [31:0] ad [5];
    logic [31:0] ex [5];
    sz = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    un = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ad = '{32'h81, 32'h81, 32'h82, 32'h82, 32'h80};
    ex = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
    for (int u = 0; u < 2; u++) begin
      do_op(u, 1, 2'd2, 0, 32'h80, 32'h8899AABB, 0, o);
      model_store(u, 2'd2, 32'h80, 32'h8899AABB);
      for (int i = 0; i < 5; i++) begin
        do_op(u, 0, sz[i], un[i], ad[i], 32'h0, 0, o);
        checks++;
        if (o.rdata !== ex[i] || o.err !== 2'd0) begin
          failures++;
          $display("FAIL load_ext u=%0d i=%0d got %h err=%0d want %h err=0",
                   u, i, o.rdata, o.err, ex[i]);
        end
        checks++;
        if (int'(o.rv_cyc) != 2 + lat_of(u)) begin
          failures++;
          $display("FAIL load_lat u=%0d i=%0d got %0d want %0d",
                   u, i, o.rv_cyc, 2 + lat_of(u));
        end
      end
    end
  endtask

  task automatic test_errors();
    obs_t o;
    int          uu [6];
    bit          st [6];
    logic [1:0]  sz [6];
    logic [31:0] ad [6];
    logic [1:0]  ee [6];
    uu = '{0, 0, 1, 1, 0, 1};
    st = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sz = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2};
    ad = '{32'h13, 32'h40, 32'h42, 32'h41, 32'h21, 32'h03};
    ee = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      do_op(uu[i], st[i], sz[i], 0, ad[i], 32'hFFFF_FFFF, 0, o);
      checks++;
      if (o.err !== ee[i] || o.rv_cyc != 1 || o.rdata !== 0) begin
        failures++;
        $display("FAIL err_resp i=%0d got err=%0d cyc=%0d rd=%h want err=%0d cyc=1 rd=0",
                 i, o.err, o.rv_cyc, o.rdata, ee[i]);
      end
      checks++;
      if (o.en_cnt != 0 || o.stray != 0) begin
        failures++;
        $display("FAIL err_no_mem i=%0d got en=%0d stray=%0d want 0 0", i, o.en_cnt, o.stray);
      end
    end
  endtask

  task automatic test_latency_hold();
    obs_t o;
    logic [31:0] w;
    w = $urandom;
    do_op(1, 1, 2'd2, 0, 32'h40, w, 0, o);
    model_store(1, 2'd2, 32'h40, w);
    do_op(1, 0, 2'd2, 0, 32'h40, 32'h0, 3, o);
    checks++;
    if (o.en_cyc != 1 || o.rv_cyc != 6) begin
      failures++;
      $display("FAIL lat4_timing got en=%0d rv=%0d want 1 6", o.en_cyc, o.rv_cyc);
    end
    checks++;
    if (o.rdata !== w) begin
      failures++;
      $display("FAIL lat4_data got %h want %h", o.rdata, w);
    end
    checks++;
    if (o.unstable != 0) begin
      failures++;
      $display("FAIL resp_hold got %0d violations want 0", o.unstable);
    end
  endtask

  task automatic test_no_accept_on_consume();
    int n;
    @(negedge clk);
    resp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_store[0] = 1'b0;
    req_size[0] = 2'd2;
    req_addr[0] = 32'h80;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL consume_wait1 got no resp_valid want within 20 cycles");
    end
    req_valid[0] = 1'b1;
    req_addr[0] = 32'h10;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL consume_accept got rdy=%b rv=%b want 1 0", req_ready[0], resp_valid[0]);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20 || resp_rdata[0] !== exp_load(0, 2'd2, 0, 32'h10)) begin
      failures++;
      $display("FAIL consume_next got %h want %h", resp_rdata[0], exp_load(0, 2'd2, 0, 32'h10));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int bad;
    @(negedge clk);
    resp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_store[0] = 1'b0;
    req_size[0] = 2'd2;
    req_addr[0] = 32'h80;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid[0] !== 1'b0 || mem_en[0] !== 1'b0 || mem_we[0] !== 4'b0 ||
        resp_rdata[0] !== 0 || resp_err[0] !== 0 ||
        mem_din[0] !== 0 || mem_addr[0] !== 0) begin
      failures++;
      $display("FAIL midreset_out got rv=%b en=%b din=%h addr=%h want all 0",
               resp_valid[0], mem_en[0], mem_din[0], mem_addr[0]);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got %b want 1", req_ready[0]);
    end
    bad = 0;
    repeat (4) begin
      if (resp_valid[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_noresp got %0d resp cycles want 0", bad);
    end
    do_op(0, 1, 2'd0, 0, 32'h02, 32'h000000A5, 0, o);
    model_store(0, 2'd0, 32'h02, 32'h000000A5);
    checks++;
    if (o.we !== 4'b0010 || o.din !== 32'hA5A5A5A5 || o.err !== 0) begin
      failures++;
      $display("FAIL sb_after_reset got we=%b din=%h err=%0d want 0010 a5a5a5a5 0",
               o.we, o.din, o.err);
    end
    do_op(0, 0, 2'd0, 1, 32'h02, 32'h0, 0, o);
    checks++;
    if (o.rdata !== 32'h000000A5) begin
      failures++;
      $display("FAIL lbu_after_reset got %h want 000000a5", o.rdata);
    end
  endtask

  task automatic test_noswap();
    obs_t o;
    do_op(1, 1, 2'd2, 0, 32'h20, 32'h11223344, 0, o);
    model_store(1, 2'd2, 32'h20, 32'h11223344);
    checks++;
    if (o.din !== 32'h11223344 || o.we !== 4'b1111) begin
      failures++;
      $display("FAIL noswap_sw got din=%h we=%b want 11223344 1111", o.din, o.we);
    end
    do_op(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, o);
    checks++;
    if (o.rdata !== 32'h11223344) begin
      failures++;
      $display("FAIL noswap_lw got %h want 11223344", o.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int u;
    bit st;
    bit un;
    int hold;
    logic [1:0]  sz;
    logic [1:0]  e;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] erd;
    logic [31:0] edin;
    logic [3:0]  ewe;
    for (int n = 0; n < 80; n++) begin
      u = $urandom_range(0, 1);
      st = 1'($urandom);
      un = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      w = $urandom;
      hold = $urandom_range(0, 2);
      e = exp_err(sz, a);
      erd = (!st && e == 0) ? exp_load(u, sz, un, a) : 32'd0;
      exp_store(u, sz, a, w, ewe, edin);
      do_op(u, st, sz, un, a, w, hold, o);
      if (st && e == 0) model_store(u, sz, a, w);
      checks++;
      if (o.err !== e || o.rdata !== erd) begin
        failures++;
        $display("FAIL rnd_resp n=%0d got err=%0d rd=%h want err=%0d rd=%h",
                 n, o.err, o.rdata, e, erd);
      end
      checks++;
      if (int'(o.rv_cyc) != ((e != 0) ? 1 : 2 + lat_of(u))) begin
        failures++;
        $display("FAIL rnd_lat n=%0d got %0d want %0d",
                 n, o.rv_cyc, (e != 0) ? 1 : 2 + lat_of(u));
      end
      checks++;
      if (int'(o.en_cnt) != ((e != 0) ? 0 : 1) || o.stray != 0) begin
        failures++;
        $display("FAIL rnd_strobe n=%0d got en=%0d stray=%0d want %0d 0",
                 n, o.en_cnt, o.stray, (e != 0) ? 0 : 1);
      end
      if (e == 0) begin
        checks++;
        if (o.addr !== {a[31:2], 2'b00} || o.we !== (st ? ewe : 4'b0000)) begin
          failures++;
          $display("FAIL rnd_bus n=%0d got addr=%h we=%b want %h %b",
                   n, o.addr, o.we, {a[31:2], 2'b00}, st ? ewe : 4'b0000);
        end
        if (st) begin
          checks++;
          if (o.din !== edin) begin
            failures++;
            $display("FAIL rnd_din n=%0d got %h want %h", n, o.din, edin);
          end
        end
      end
      checks++;
      if (o.unstable != 0 || o.rdy !== 1'b1) begin
        failures++;
        $display("FAIL rnd_hs n=%0d got unstable=%0d rdy=%b want 0 1", n, o.unstable, o.rdy);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    clr_mem = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_store[u] = 1'b0;
      req_size[u] = 2'd0;
      req_unsigned[u] = 1'b0;
      req_addr[u] = 32'd0;
      req_wdata[u] = 32'd0;
      resp_ready[u] = 1'b1;
    end
    test_reset();
    test_store_word();
    test_load_ext();
    test_errors();
    test_latency_hold();
    test_no_accept_on_consume();
    test_reset_mid();
    test_noswap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
